alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Byte-stream instruction sequencer for an external registered ALU.
// Decodes opcode/immediate bytes, issues one ALU cycle, captures the result and hands it out.
module alu_sequencer #(
    parameter bit QUIET_NOP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_opcode,
    output logic       alu_accum_source,
    output logic       alu_value_source,
    output logic [7:0] alu_data_in,
    input  logic [7:0] alu_data_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IMM,
        S_ISSUE,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_run;
    logic [3:0] r_op;
    logic       r_acc;
    logic       r_val;
    logic [3:0] r_issue_op;
    logic       r_alu_acc;
    logic       r_alu_val;
    logic [7:0] r_alu_data;
    logic [7:0] r_out_data;

    logic       w_accept;
    logic       w_needs_imm;
    logic       w_latch;
    logic       w_load_issue;
    logic       w_capture;
    logic [3:0] w_issue_op;
    logic       w_issue_acc;
    logic       w_issue_val;
    logic [7:0] w_issue_data;
    logic       w_unused;

    // Opcodes that are self-contained never fetch an immediate byte.
    function automatic logic op_takes_imm(input logic [3:0] op);
        case (op)
            4'h0, 4'h4, 4'h5, 4'h7, 4'hF: op_takes_imm = 1'b0;
            default:                      op_takes_imm = 1'b1;
        endcase
    endfunction

    assign w_unused    = ^in_data[1:0];
    assign in_ready    = r_run && (r_state == S_IDLE || r_state == S_IMM);
    assign w_accept    = in_valid && in_ready;
    assign w_needs_imm = !in_data[2] && op_takes_imm(in_data[7:4]);

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_load_issue = 1'b0;
        w_capture    = 1'b0;
        w_issue_op   = r_op;
        w_issue_acc  = r_acc;
        w_issue_val  = r_val;
        w_issue_data = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_needs_imm) begin
                        w_state_next = S_IMM;
                        w_latch      = 1'b1;
                    end else if (!(QUIET_NOP && in_data[7:4] == 4'h0)) begin
                        w_state_next = S_ISSUE;
                        w_load_issue = 1'b1;
                        w_issue_op   = in_data[7:4];
                        w_issue_acc  = in_data[3];
                        w_issue_val  = in_data[2];
                    end
                end
            end
            S_IMM: begin
                if (w_accept) begin
                    w_state_next = S_ISSUE;
                    w_load_issue = 1'b1;
                    w_issue_data = in_data;
                end
            end
            S_ISSUE:   w_state_next = S_CAPTURE;
            S_CAPTURE: begin
                w_state_next = S_OUT;
                w_capture    = 1'b1;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    // ALU operand registers load only on entry to ISSUE so they hold the last-issued values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_op       <= 4'h0;
            r_acc      <= 1'b0;
            r_val      <= 1'b0;
            r_issue_op <= 4'h0;
            r_alu_acc  <= 1'b0;
            r_alu_val  <= 1'b0;
            r_alu_data <= 8'h00;
            r_out_data <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            if (w_latch) begin
                r_op  <= in_data[7:4];
                r_acc <= in_data[3];
                r_val <= in_data[2];
            end
            if (w_load_issue) begin
                r_issue_op <= w_issue_op;
                r_alu_acc  <= w_issue_acc;
                r_alu_val  <= w_issue_val;
                r_alu_data <= w_issue_data;
            end
            if (w_capture) begin
                r_out_data <= alu_data_out;
            end
        end
    end

    assign alu_opcode       = (r_state == S_ISSUE) ? r_issue_op : 4'h0;
    assign alu_accum_source = r_alu_acc;
    assign alu_value_source = r_alu_val;
    assign alu_data_in      = r_alu_data;
    assign out_data         = r_out_data;
    assign out_valid        = (r_state == S_OUT);
    assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a stand-in registered ALU answers the DUT, and a byte-level
// reference of the accumulators predicts every result.
module tb_alu_sequencer;

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] a1;
        logic       c;
        logic       z;
        logic [7:0] out;
    } alu_st_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_opcode;
    logic       alu_accum_source;
    logic       alu_value_source;
    logic [7:0] alu_data_in;
    logic [7:0] alu_data_out;
    logic       busy;

    logic [7:0] q_in_data = 8'h00;
    logic       q_in_valid = 1'b0;
    logic       q_in_ready;
    logic [7:0] q_out_data;
    logic       q_out_valid;
    logic       q_out_ready = 1'b1;
    logic [3:0] q_alu_opcode;
    logic       q_alu_accum_source;
    logic       q_alu_value_source;
    logic [7:0] q_alu_data_in;
    logic [7:0] q_alu_data_out;
    logic       q_busy;

    int      n_checks = 0;
    int      n_fail = 0;
    int      issue_count = 0;
    alu_st_t env_st;
    alu_st_t ref_st = '0;

    always #5 clk = ~clk;

    alu_sequencer #(.QUIET_NOP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .alu_accum_source(alu_accum_source),
        .alu_value_source(alu_value_source), .alu_data_in(alu_data_in),
        .alu_data_out(alu_data_out), .busy(busy)
    );

    alu_sequencer #(.QUIET_NOP(1'b1)) dut_q (
        .clk(clk), .rst_n(rst_n), .in_data(q_in_data), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .out_data(q_out_data), .out_valid(q_out_valid), .out_ready(q_out_ready),
        .alu_opcode(q_alu_opcode), .alu_accum_source(q_alu_accum_source),
        .alu_value_source(q_alu_value_source), .alu_data_in(q_alu_data_in),
        .alu_data_out(q_alu_data_out), .busy(q_busy)
    );

    // Behaviour of the ALU stand-in: accumulator select, operand select, flags.
    function automatic alu_st_t alu_step(input alu_st_t s, input logic [3:0] op,
                                         input logic src, input logic vsel, input logic [7:0] imm);
        alu_st_t    n;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] t;
        logic       wr;
        n  = s;
        a  = src ? s.a1 : s.a0;
        b  = vsel ? (src ? s.a0 : s.a1) : imm;
        t  = {1'b0, a};
        wr = 1'b1;
        case (op)
            4'h0: wr = 1'b0;
            4'h1: t = {s.c, b};
            4'h2: t = {1'b0, a} + {1'b0, b};
            4'h3: t = {1'b0, a} - {1'b0, b};
            4'h4: t = 9'h000;
            4'h5: t = {1'b0, a} - 9'd1;
            4'h6: t = {s.c, a & b};
            4'h7: t = {s.c, ~a};
            4'h8: t = {s.c, a | b};
            4'h9: t = {s.c, a ^ b};
            4'hA: t = {s.c, a << b[2:0]};
            4'hB: t = {s.c, a >> b[2:0]};
            4'hC: t = {s.c, a + b + {7'd0, s.c}};
            4'hD: t = {s.c, b - a};
            4'hE: t = {s.c, (a > b) ? a : b};
            default: wr = 1'b0;
        endcase
        if (op inside {4'h2, 4'h3, 4'h4, 4'h5}) n.c = t[8];
        if (op >= 4'h2 && op <= 4'hE) n.z = (t[7:0] == 8'h00);
        if (wr) begin
            if (src) n.a1 = t[7:0];
            else     n.a0 = t[7:0];
        end
        n.out = (op == 4'hF) ? {5'b0, n.c, 1'b0, n.z} : (wr ? t[7:0] : a);
        return n;
    endfunction

    function automatic bit takes_imm(input logic [7:0] ins);
        return !ins[2] && !(ins[7:4] inside {4'h0, 4'h4, 4'h5, 4'h7, 4'hF});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) env_st <= '0;
        else        env_st <= alu_step(env_st, alu_opcode, alu_accum_source, alu_value_source, alu_data_in);
    end
    assign alu_data_out = env_st.out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    q_alu_data_out <= 8'h00;
        else if (q_alu_opcode == 4'h1) q_alu_data_out <= q_alu_data_in;
    end

    always @(posedge clk) begin
        if (rst_n && alu_opcode != 4'h0) issue_count <= issue_count + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n  = 1'b1;
        ref_st = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept: byte %h not accepted within 50 cycles (in_ready=%b, want 1)", b, in_ready);
        end
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic [7:0] imm, input int gap, input int hold);
        bit         needs;
        bit         ok;
        bit         bad;
        logic [7:0] eimm;
        alu_st_t    nxt;
        int         base;
        logic [7:0] held;
        needs = takes_imm(ins);
        eimm  = needs ? imm : 8'h00;
        base  = issue_count;
        nxt   = alu_step(ref_st, ins[7:4], ins[3], ins[2], eimm);
        send_byte(ins, ok);
        if (needs) begin
            bad = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (in_ready !== 1'b1 || busy !== 1'b1 || alu_opcode !== 4'h0) bad = 1'b1;
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (bad || issue_count != base) begin
                n_fail++;
                $display("FAIL imm_stall: ins %h issues=%0d want %0d, ready=%b busy=%b op=%h", ins,
                         issue_count - base, 0, in_ready, busy, alu_opcode);
            end
            send_byte(imm, ok);
        end
        n_checks++;
        if ({alu_opcode, alu_accum_source, alu_value_source, alu_data_in, in_ready, out_valid} !==
            {ins[7:4], ins[3], ins[2], eimm, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL issue_fields: ins %h got op=%h acc=%b val=%b din=%h rdy=%b ov=%b want op=%h acc=%b val=%b din=%h rdy=0 ov=0",
                     ins, alu_opcode, alu_accum_source, alu_value_source, alu_data_in, in_ready, out_valid,
                     ins[7:4], ins[3], ins[2], eimm);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (alu_opcode !== 4'h0 || alu_data_in !== eimm || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_cycle: ins %h got op=%h din=%h ov=%b rdy=%b want op=0 din=%h ov=0 rdy=0",
                     ins, alu_opcode, alu_data_in, out_valid, in_ready, eimm);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== nxt.out) begin
            n_fail++;
            $display("FAIL result: ins %h imm %h got valid=%b data=%h want valid=1 data=%h",
                     ins, eimm, out_valid, out_data, nxt.out);
        end
        out_ready = 1'b0;
        held      = out_data;
        bad       = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) bad = 1'b1;
        end
        if (hold > 0) begin
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL out_hold: ins %h got valid=%b data=%h rdy=%b want valid=1 data=%h rdy=0",
                         ins, out_valid, out_data, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            issue_count != base + ((ins[7:4] != 4'h0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL release: ins %h got valid=%b busy=%b rdy=%b issues=%0d want 0 0 1 %0d",
                     ins, out_valid, busy, in_ready, issue_count - base, (ins[7:4] != 4'h0) ? 1 : 0);
        end
        $display("txn ins=%h imm=%h out=%h expected=%h", ins, eimm, out_data, nxt.out);
        ref_st = nxt;
    endtask

    task automatic test_reset();
        do_reset();
        run_instr(8'h1C, 8'h77, 0, 0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_data, alu_opcode, alu_accum_source, alu_value_source, alu_data_in, busy} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b ov=%b od=%h op=%h acc=%b val=%b din=%h busy=%b want all zero",
                     in_ready, out_valid, out_data, alu_opcode, alu_accum_source, alu_value_source, alu_data_in, busy);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        ref_st = '0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_load_imm();
        do_reset();
        run_instr(8'h10, 8'h2A, 0, 0);
        n_checks++;
        if (out_data !== 8'h2A) begin
            n_fail++;
            $display("FAIL load_imm: got %h want 2a", out_data);
        end
    endtask

    task automatic test_add_flags();
        run_instr(8'h10, 8'hFF, 0, 0);
        run_instr(8'h20, 8'h01, 0, 0);
        run_instr(8'hF0, 8'h00, 0, 0);
        n_checks++;
        if (out_data !== 8'h05) begin
            n_fail++;
            $display("FAIL flags: got %h want 05", out_data);
        end
    endtask

    task automatic test_accum_source();
        do_reset();
        run_instr(8'h18, 8'h07, 0, 0);
        run_instr(8'h24, 8'h00, 0, 0);
        n_checks++;
        if (out_data !== 8'h07) begin
            n_fail++;
            $display("FAIL accum_source_add: got %h want 07", out_data);
        end
        run_instr(8'h4C, 8'h00, 0, 0);
    endtask

    task automatic test_backpressure();
        run_instr(8'h10, 8'hC3, 0, 5);
    endtask

    task automatic test_reset_mid_imm();
        bit ok;
        int base;
        send_byte(8'h20, ok);
        repeat (2) @(posedge clk);
        base = issue_count;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b rdy=%b want 0 0", busy, in_ready);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        ref_st = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (issue_count != base || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_issue: got issues=%0d ov=%b want 0 0", issue_count - base, out_valid);
        end
        run_instr(8'h40, 8'h00, 0, 0);
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL after_reset_result: got %h want 00", out_data);
        end
    endtask

    task automatic test_nop();
        run_instr(8'h10, 8'h99, 0, 0);
        run_instr(8'h00, 8'h00, 0, 0);
        n_checks++;
        if (out_data !== 8'h99) begin
            n_fail++;
            $display("FAIL nop_result: got %h want 99", out_data);
        end
    endtask

    task automatic test_quiet_nop();
        bit bad;
        bad        = 1'b0;
        q_in_data  = 8'h00;
        q_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (q_in_ready !== 1'b1 || q_busy !== 1'b0 || q_out_valid !== 1'b0) bad = 1'b1;
        end
        q_in_valid = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL quiet_nop: got rdy=%b busy=%b ov=%b want 1 0 0", q_in_ready, q_busy, q_out_valid);
        end
        q_in_data  = 8'h10;
        q_in_valid = 1'b1;
        @(posedge clk);
        #1;
        q_in_data = 8'h5A;
        @(posedge clk);
        #1;
        q_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q_out_valid !== 1'b1 || q_out_data !== 8'h5A || q_alu_accum_source !== 1'b0 || q_alu_value_source !== 1'b0) begin
            n_fail++;
            $display("FAIL quiet_after_nop: got ov=%b data=%h acc=%b val=%b want 1 5a 0 0",
                     q_out_valid, q_out_data, q_alu_accum_source, q_alu_value_source);
        end
        $display("txn quiet ins=10 imm=5a out=%h expected=5a", q_out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [7:0] ins;
        logic [7:0] imm;
        for (int i = 0; i < 40; i++) begin
            ins       = 8'($urandom_range(0, 255));
            imm       = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            run_instr(ins, imm, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_add_flags();
        test_accum_source();
        test_backpressure();
        test_reset_mid_imm();
        test_nop();
        test_quiet_nop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
